trace_serial_sched: RTL and testbench
=====================================

Name: trace_serial_sched

Overview:
Shared-channel scheduler for the 2-bit serial trace port. Up to N_REQ requesters each present a 64-bit word. The block round-robin arbitrates between them, captures the granted word in four 16-bit slices, then streams it out LSB-first as 2-bit symbols with framing and a completion ack. It sits between the bus-side capture points and the single serial output pin pair.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 64, word width per requester
SLICE, 16, bits captured per CAPTURE cycle; W/SLICE slices
SYM, 2, bits emitted per SHIFT cycle; W/SYM symbols

Ports:
clk  in  1  system clock, all logic on rising edge
rst_all_n  in  1  reset, synchronous, active-low
req  in  N_REQ  per-requester transfer request, level
data  in  N_REQ*W  requester i word at data[i*W +: W]; must be stable from grant until ack
abort  in  1  synchronous cancel of the current frame
ack  out  N_REQ  one-cycle completion pulse to the granted requester
busy  out  1  high in any state other than IDLE
sout  out  SYM  serial symbol
sout_valid  out  1  sout is valid this cycle
sout_sof  out  1  first symbol of frame
sout_eof  out  1  last symbol of frame
sout_id  out  clog2(N_REQ)  index of the requester owning the frame

Behaviour:
- Reset (rst_all_n=0 at a clock edge): state=IDLE; all outputs 0; shift register 0; counter 0; round-robin pointer 0.
- FSM: IDLE -> CAPTURE -> SHIFT -> DONE -> IDLE. All outputs are registered.
- IDLE: if any req is high, latch the grant index g (round-robin search starting at the pointer). Go to CAPTURE next cycle with ctr=0. If no req is high, remain in IDLE.
- Round robin: after a grant to g, the pointer becomes (g+1) mod N_REQ. A lone requester can be granted on back-to-back frames.
- CAPTURE: lasts W/SLICE cycles (4). On ctr=k, store data[g][k*SLICE +: SLICE] into K[k*SLICE +: SLICE]; other bits of K hold. After the last slice, go to SHIFT with ctr=0.
- SHIFT: lasts W/SYM cycles (32).
  - sout=K[SYM-1:0], sout_valid=1, sout_id=g.
  - K shifts right by SYM each cycle; zeros fill the top.
  - sout_sof=1 on ctr=0 only; sout_eof=1 on ctr=W/SYM-1 only.
  - After the last symbol, go to DONE.
- DONE: ack[g]=1 for exactly one cycle, then IDLE. sout_valid=0.
- Latency: req high at the edge in IDLE (cycle t) gives:
  - CAPTURE at t+1..t+4
  - sout_valid at t+5..t+36
  - ack at t+37
  - IDLE at t+38
  - Frame period is 38 cycles.
- req dropped mid-frame: ignored. The frame completes and ack is still issued.
- req still high in the IDLE cycle after ack: treated as a new request, subject to round robin.
- abort=1 in CAPTURE or SHIFT: next state IDLE, no ack, and sout_valid/sof/eof are 0 from the next cycle. The pointer has already advanced. abort in IDLE or DONE has no effect; DONE still acks.
- abort and the last SHIFT symbol in the same cycle: abort wins, no ack.
- Counter width is clog2(max(W/SLICE, W/SYM)). No wrap occurs because state transitions on the terminal count.
- Outputs sout, sof, eof and id are 0 whenever sout_valid=0.

Decomposition:
- Package trace_sched_pkg holds:
  - state enum (IDLE, CAPTURE, SHIFT, DONE)
  - derived constants N_SLICE=W/SLICE, N_SYM=W/SYM, CTR_W, ID_W
- One sub-module, rr_arbiter (N_REQ): inputs req, pointer, grant_en; outputs one-hot grant, encoded index, any_req. Purely combinational search, with the pointer register inside.

Test Plan:
- Single frame: req[0]=1, data[0]=64'h0123456789ABCDEF at t.
  - sout at t+5..t+8 = 3,3,2,3; sof at t+5; eof at t+36 with sout=0 (top nibble 0).
  - ack[0] at t+37; sout_id=0 throughout.
- Round robin: req=4'b1111 held with distinct data (data[i]=i replicated).
  - Frames are owned by ids 0,1,2,3,0 in that order; each frame has 32 valid symbols; next sof occurs 38 cycles after the previous sof.
- Abort: req[2]=1, abort pulsed on the 10th SHIFT cycle.
  - sout_valid=0 next cycle, no ack[2], busy=0 one cycle later.
  - With req[2] still high, the next frame is granted to id 2 (only requester).
- Abort/eof collision: abort on the eof cycle -> no ack; the next frame starts normally.
- Mid-frame reset: rst_all_n=0 during SHIFT for one edge -> the next cycle has all outputs 0 and state IDLE; the pointer restarts at 0 (req=4'b0110 grants id 1 first).
- Req withdrawal: req[1] dropped after CAPTURE -> full 32-symbol frame, ack[1] still pulses, then IDLE stays idle with req=0.

Source files
------------

// File: rtl/trace_sched_pkg.sv
// Shared types and derived constants for the serial trace scheduler.
package trace_sched_pkg;
  localparam int W         = 64;
  localparam int SLICE     = 16;
  localparam int SYM       = 2;
  localparam int N_REQ_DEF = 4;
  localparam int N_SLICE   = W / SLICE;
  localparam int N_SYM     = W / SYM;
  localparam int CTR_W     = $clog2((N_SYM > N_SLICE) ? N_SYM : N_SLICE);
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/trace_serial_sched_rr_arbiter.sv
// Round-robin requester search; the rotating pointer lives here and advances
// past the winner whenever the caller accepts a grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any_req
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cand_s;

  // First active requester at or after the pointer, wrapping around
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!any_req && req[cand_s]) begin
        any_req = 1'b1;
        idx     = cand_s;
      end else begin
        any_req = any_req;
      end
    end
  end

  // One-hot form of the winning index
  always_comb begin
    grant = '0;
    if (any_req) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Pointer moves just past the accepted winner
  always_comb begin
    if (grant_en && any_req) begin
      ptr_d = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/trace_serial_sched.sv
// Shared 2-bit serial trace port: arbitrate, capture a word in slices, then
// stream it LSB-first with framing, owner id and a completion ack.
module trace_serial_sched import trace_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDW  = (N_REQ == N_REQ_DEF) ? ID_W : $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_all_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data,
  input  logic               abort,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [SYM-1:0]     sout,
  output logic               sout_valid,
  output logic               sout_sof,
  output logic               sout_eof,
  output logic [IDW-1:0]     sout_id
);
  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [W-1:0]       k_q, k_d;
  logic [IDW-1:0]     g_q, g_d;
  logic [N_REQ-1:0]   goh_q, goh_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [SYM-1:0]     sout_q, sout_d;
  logic               valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [N_REQ-1:0]   arb_grant_s;
  logic [IDW-1:0]     arb_idx_s;
  logic               arb_any_s;
  logic [W-1:0]       word_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_all_n),
    .req      (req),
    .grant_en (state_q == ST_IDLE),
    .grant    (arb_grant_s),
    .idx      (arb_idx_s),
    .any_req  (arb_any_s)
  );

  // Word of the current owner, selected with constant slice bases
  always_comb begin
    word_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (g_q == IDW'(r)) begin
        word_s = data[r*W +: W];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Next state, datapath and registered-output values
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    k_d     = k_q;
    g_d     = g_q;
    goh_d   = goh_q;
    ack_d   = '0;
    busy_d  = (state_q != ST_IDLE);
    sout_d  = '0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    id_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          g_d     = arb_idx_s;
          goh_d   = arb_grant_s;
          ctr_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          ctr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          for (int s = 0; s < N_SLICE; s++) begin
            if (ctr_q == CTR_W'(s)) begin
              k_d[s*SLICE +: SLICE] = word_s[s*SLICE +: SLICE];
            end else begin
              k_d[s*SLICE +: SLICE] = k_d[s*SLICE +: SLICE];
            end
          end
          if (ctr_q == CTR_W'(N_SLICE - 1)) begin
            ctr_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // Abort beats the final symbol: nothing is emitted and no ack follows
        if (abort) begin
          ctr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          sout_d  = k_q[SYM-1:0];
          valid_d = 1'b1;
          sof_d   = (ctr_q == '0);
          eof_d   = (ctr_q == CTR_W'(N_SYM - 1));
          id_d    = g_q;
          k_d     = k_q >> SYM;
          if (ctr_q == CTR_W'(N_SYM - 1)) begin
            ctr_d   = '0;
            state_d = ST_DONE;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        ack_d   = goh_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_all_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      k_q     <= '0;
      g_q     <= '0;
      goh_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      sout_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      k_q     <= k_d;
      g_q     <= g_d;
      goh_q   <= goh_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      id_q    <= id_d;
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_sof   = sof_q;
  assign sout_eof   = eof_q;
  assign sout_id    = id_q;
endmodule

// File: tb/tb_trace_serial_sched.sv
// Directed bench for trace_serial_sched with a frame-timeline reference model.
module tb_trace_serial_sched;
  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_all_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic           abort = 1'b0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     sout;
  logic           sout_valid, sout_sof, sout_eof;
  logic [1:0]     sout_id;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  // expected outputs after the most recent rising edge
  logic [N-1:0] e_ack;
  logic e_busy, e_valid, e_sof, e_eof;
  logic [1:0] e_sout, e_id;

  // model state: a frame is a timeline of offsets from its grant edge
  bit m_active = 1'b0;
  int m_ptr = 0, m_g = 0, m_o = 0;
  logic [W-1:0] m_word;

  // frame monitor
  int sof_cyc[$];
  int sof_id[$];
  int cnt_q[$];
  int run = 0;

  trace_serial_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst_all_n(rst_all_n), .req(req), .data(data), .abort(abort),
    .ack(ack), .busy(busy), .sout(sout), .sout_valid(sout_valid),
    .sout_sof(sout_sof), .sout_eof(sout_eof), .sout_id(sout_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: grant at an idle edge, symbols at offsets 5..36, ack at 37
  initial forever begin
    @(posedge clk);
    cyc++;
    started = 1'b1;
    e_ack = '0; e_busy = 1'b0; e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
    e_sout = '0; e_id = '0;
    if (!rst_all_n) begin
      m_active = 1'b0;
      m_ptr = 0;
    end else if (m_active) begin
      m_o++;
      e_busy = 1'b1;
      if (abort && m_o <= 36) begin
        m_active = 1'b0;
      end else if (m_o >= 5 && m_o <= 36) begin
        e_valid = 1'b1;
        e_sof = (m_o == 5);
        e_eof = (m_o == 36);
        e_id = 2'(m_g);
        e_sout = 2'((m_word >> (2 * (m_o - 5))) & 64'd3);
      end else if (m_o == 37) begin
        e_ack = 4'(1 << m_g);
        m_active = 1'b0;
      end
    end else if (req != '0) begin
      m_g = -1;
      for (int k = 0; k < N; k++) begin
        if (m_g < 0 && req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
      m_ptr = (m_g + 1) % N;
      m_word = data[m_g*W +: W];
      m_active = 1'b1;
      m_o = 0;
    end
  end

  // Per-cycle compare against the model, plus frame bookkeeping
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("cycle_outputs", {ack, busy, sout, sout_valid, sout_sof, sout_eof, sout_id},
          {e_ack, e_busy, e_sout, e_valid, e_sof, e_eof, e_id});
    end
    if (sout_valid === 1'b1) begin
      if (sout_sof === 1'b1) begin
        sof_cyc.push_back(cyc);
        sof_id.push_back(int'(sout_id));
        run = 0;
      end
      run++;
      if (sout_eof === 1'b1) cnt_q.push_back(run);
    end
  end

  initial begin
    // reset state
    tick(3);
    chk("reset_outputs", {ack, busy, sout, sout_valid, sout_sof, sout_eof, sout_id}, 12'd0);
    rst_all_n = 1'b1;
    tick(1);

    // single frame, requester 0
    data[0 +: W] = 64'h0123456789ABCDEF;
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    tick(5);
    chk("t1_sym0", sout, 2'd3);
    chk("t1_sof", {sout_valid, sout_sof, sout_id}, 4'b1100);
    tick(1); chk("t1_sym1", sout, 2'd3);
    tick(1); chk("t1_sym2", sout, 2'd2);
    tick(1); chk("t1_sym3", sout, 2'd3);
    tick(28);
    chk("t1_eof", {sout_valid, sout_eof, sout}, 4'b1100);
    tick(1); chk("t1_ack", ack, 4'b0001);
    tick(1); chk("t1_idle", {busy, ack}, 5'd0);
    tick(3);

    // round robin across all four requesters
    rst_all_n = 1'b0;
    tick(1);
    rst_all_n = 1'b1;
    tick(1);
    sof_cyc.delete(); sof_id.delete(); cnt_q.delete();
    for (int i = 0; i < N; i++) data[i*W +: W] = {16{4'(i)}};
    req = 4'b1111;
    tick(160);
    req = 4'b0000;
    tick(45);
    chk("rr_frames", sof_id.size(), 5);
    if (sof_id.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_id", sof_id[i], i % 4);
      for (int i = 1; i < 5; i++) chk("rr_gap", sof_cyc[i] - sof_cyc[i-1], 38);
    end
    chk("rr_counts", cnt_q.size(), 5);
    foreach (cnt_q[i]) chk("rr_len", cnt_q[i], 32);

    // abort on the 10th symbol, requester 2 regranted
    data[2*W +: W] = 64'hA5A55A5AF0F00F0F;
    req = 4'b0100;
    tick(14);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_stop", {sout_valid, ack, busy}, 6'b000001);
    tick(1); chk("ab_idle", busy, 1'b0);
    tick(1); chk("ab_regrant", busy, 1'b1);
    tick(4); chk("ab_sof", {sout_valid, sout_sof, sout_id}, 4'b1110);
    req = 4'b0000;
    tick(40);

    // abort coincides with the last symbol
    data[3*W +: W] = 64'hC3C33C3C12345678;
    req = 4'b1000;
    tick(36);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ae_noeof", {sout_valid, sout_eof}, 2'b00);
    tick(1); chk("ae_noack", ack, 4'b0000);
    tick(5); chk("ae_next_sof", {sout_valid, sout_sof, sout_id}, 4'b1111);
    req = 4'b0000;
    tick(40);

    // reset during SHIFT restarts the pointer
    req = 4'b0010;
    tick(20);
    rst_all_n = 1'b0;
    req = 4'b0000;
    tick(1);
    chk("rs_outputs", {ack, busy, sout, sout_valid, sout_sof, sout_eof, sout_id}, 12'd0);
    rst_all_n = 1'b1;
    req = 4'b0110;
    tick(1);
    req = 4'b0000;
    tick(5);
    chk("rs_first_id", {sout_valid, sout_sof, sout_id}, 4'b1101);
    tick(40);

    // requester withdraws after capture
    cnt_q.delete();
    data[1*W +: W] = 64'h123456789ABCDEF0;
    req = 4'b0010;
    tick(5);
    req = 4'b0000;
    tick(33);
    chk("wd_ack", ack, 4'b0010);
    tick(7);
    chk("wd_idle", {busy, sout_valid}, 2'b00);
    chk("wd_len", (cnt_q.size() == 1) ? cnt_q[0] : -1, 32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
